aoi: RTL and testbench



---
 rtl/aoi_pkg.sv | 19 +
 rtl/aoi_lane.sv | 36 +++
 rtl/aoi.sv | 68 ++++++
 tb/tb_aoi.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aoi_pkg.sv
// ---------------------------------------------------------------------------
// aoi_pkg
// Shared definitions for the registered and-or-invert stage.
//   aoi_mode_t     : per-lane function select (AOI22 / OAI22 / AOI21 / AO22)
//   AOI_RESET_VAL  : per-lane value of the output register after reset, which
//                    is the AOI22 result of all-zero operands
// ---------------------------------------------------------------------------
package aoi_pkg;

    typedef enum logic [1:0] {
        AOI_MODE_AOI22 = 2'd0,
        AOI_MODE_OAI22 = 2'd1,
        AOI_MODE_AOI21 = 2'd2,
        AOI_MODE_AO22  = 2'd3
    } aoi_mode_t;

    localparam logic AOI_RESET_VAL = 1'b1;

endpackage : aoi_pkg

// File: rtl/aoi_lane.sv
// ---------------------------------------------------------------------------
// aoi_lane
// Single-bit combinational and-or-invert cell with a selectable function.
// Ports:
//   a, b, c, d : operand bits
//   mode       : function select (aoi_mode_t)
//   f          : selected function of the operands
// ---------------------------------------------------------------------------
module aoi_lane
    import aoi_pkg::*;
(
    input  logic      a,
    input  logic      b,
    input  logic      c,
    input  logic      d,
    input  aoi_mode_t mode,
    output logic      f
);

    logic f_s;

    // Per-lane function select; d is unused by AOI21.
    always_comb begin
        f_s = AOI_RESET_VAL;
        case (mode)
            AOI_MODE_AOI22: f_s = ~((a & b) | (c & d));
            AOI_MODE_OAI22: f_s = ~((a | b) & (c | d));
            AOI_MODE_AOI21: f_s = ~((a & b) | c);
            AOI_MODE_AO22:  f_s = (a & b) | (c & d);
            default:        f_s = ~((a & b) | (c & d));
        endcase
    end

    assign f = f_s;

endmodule : aoi_lane

// File: rtl/aoi.sv
// ---------------------------------------------------------------------------
// aoi
// Registered and-or-invert stage over WIDTH independent lanes.
// Ports:
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   a, b, c, d  : WIDTH-bit operands
//   mode        : function select, captured together with the operands
//   in_valid    : operands/mode valid this cycle
//   y_comb      : combinational result of the current inputs
//   y           : result registered on the last valid edge
//   y_valid     : y was captured on the previous edge
// ---------------------------------------------------------------------------
module aoi
    import aoi_pkg::*;
#(
    parameter int unsigned WIDTH = 1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y_comb,
    output logic [WIDTH-1:0] y,
    output logic             y_valid
);

    aoi_mode_t        mode_s;
    logic [WIDTH-1:0] y_comb_s;
    logic [WIDTH-1:0] y_r;
    logic             y_valid_r;

    assign mode_s = aoi_mode_t'(mode);

    // One independent cell per lane; no cross-lane terms exist.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        aoi_lane u_lane (
            .a    (a[i]),
            .b    (b[i]),
            .c    (c[i]),
            .d    (d[i]),
            .mode (mode_s),
            .f    (y_comb_s[i])
        );
    end

    // Output register and valid flag; reset wins over a pending capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_r       <= {WIDTH{AOI_RESET_VAL}};
            y_valid_r <= 1'b0;
        end else if (in_valid) begin
            y_r       <= y_comb_s;
            y_valid_r <= 1'b1;
        end else begin
            y_r       <= y_r;
            y_valid_r <= 1'b0;
        end
    end

    assign y_comb  = y_comb_s;
    assign y       = y_r;
    assign y_valid = y_valid_r;

endmodule : aoi

// File: tb/tb_aoi.sv
// ---------------------------------------------------------------------------
// tb_aoi
// Self-checking bench for aoi. Two instances share the stimulus: an 8-lane
// one and a 1-lane one wired to bit 0 of the same buses.
// ---------------------------------------------------------------------------
module tb_aoi;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a, b, c, d;
    logic [1:0] mode;
    logic       in_valid;
    logic [7:0] y_comb8, y8;
    logic       y_valid8;
    logic       y_comb1, y1, y_valid1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    aoi #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .mode(mode),
        .in_valid(in_valid), .y_comb(y_comb8), .y(y8), .y_valid(y_valid8)
    );

    aoi #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .a(a[0]), .b(b[0]), .c(c[0]), .d(d[0]), .mode(mode),
        .in_valid(in_valid), .y_comb(y_comb1), .y(y1), .y_valid(y_valid1)
    );

    // Reference: per lane, counts of true terms decide the result.
    function automatic logic [7:0] ref_f(input logic [7:0] fa, fb, fc, fd, input int m);
        logic [7:0] r;
        int ab, cd, aorb, cord;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            ab   = int'(fa[i]) * int'(fb[i]);
            cd   = int'(fc[i]) * int'(fd[i]);
            aorb = int'(fa[i]) + int'(fb[i]);
            cord = int'(fc[i]) + int'(fd[i]);
            case (m)
                0:       r[i] = (ab + cd == 0);
                1:       r[i] = !((aorb > 0) && (cord > 0));
                2:       r[i] = (ab + int'(fc[i]) == 0);
                3:       r[i] = (ab + cd > 0);
                default: r[i] = 1'bx;
            endcase
        end
        return r;
    endfunction

    task automatic set_scalar(input logic [3:0] abcd, input logic [1:0] m, input logic v);
        a = {8{abcd[3]}};
        b = {8{abcd[2]}};
        c = {8{abcd[1]}};
        d = {8{abcd[0]}};
        mode = m;
        in_valid = v;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        set_scalar(4'b1111, 2'd0, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (y8 !== 8'hFF || y_valid8 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset8: y=%h y_valid=%b want y=ff y_valid=0", y8, y_valid8);
        end
        n_cmp++;
        if (y1 !== 1'b1 || y_valid1 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset1: y=%b y_valid=%b want y=1 y_valid=0", y1, y_valid1);
        end
        n_cmp++;
        if (y_comb8 !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_comb: y_comb=%h want 00", y_comb8);
        end
    endtask

    task automatic test_sweep_aoi22();
        logic [3:0] pat [11] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0111,
                                 4'b1000, 4'b1001, 4'b1100, 4'b0011, 4'b1111};
        logic       expv [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                                  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       prev = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (i < 11) set_scalar(pat[i], 2'd0, 1'b1);
            else        in_valid = 1'b0;
            @(negedge clk);
            if (i < 11) begin
                n_cmp++;
                if (y_comb8 !== {8{expv[i]}} || y_comb1 !== expv[i]) begin
                    n_bad++;
                    $display("FAIL sweep_comb abcd=%b: y_comb8=%h y_comb1=%b want %b",
                             pat[i], y_comb8, y_comb1, expv[i]);
                end
            end
            if (i > 0) begin
                n_cmp++;
                if (y8 !== {8{prev}} || y1 !== prev || y_valid8 !== 1'b1 || y_valid1 !== 1'b1) begin
                    n_bad++;
                    $display("FAIL sweep_reg step %0d: y8=%h y1=%b v8=%b v1=%b want y=%b valid=1",
                             i, y8, y1, y_valid8, y_valid1, prev);
                end
            end
            if (i < 11) prev = expv[i];
        end
    endtask

    task automatic test_modes();
        logic [1:0] md   [6] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
        logic [3:0] pat  [6] = '{4'b1010, 4'b1010, 4'b1010, 4'b0001, 4'b0001, 4'b0001};
        logic       expv [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic       prev = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            if (i < 6) set_scalar(pat[i], md[i], 1'b1);
            else       in_valid = 1'b0;
            @(negedge clk);
            if (i < 6) begin
                n_cmp++;
                if (y_comb8 !== {8{expv[i]}} || y_comb1 !== expv[i]) begin
                    n_bad++;
                    $display("FAIL mode%0d_comb abcd=%b: y_comb8=%h y_comb1=%b want %b",
                             md[i], pat[i], y_comb8, y_comb1, expv[i]);
                end
            end
            if (i > 0) begin
                n_cmp++;
                if (y8 !== {8{prev}} || y_valid8 !== 1'b1 || y1 !== prev) begin
                    n_bad++;
                    $display("FAIL mode_reg step %0d: y8=%h y1=%b v=%b want y=%b valid=1",
                             i, y8, y1, y_valid8, prev);
                end
            end
            if (i < 6) prev = expv[i];
        end
    endtask

    task automatic test_reset_midstream();
        @(posedge clk); #1;
        rst = 1'b1;
        set_scalar(4'b1111, 2'd0, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (y8 !== 8'hFF || y_valid8 !== 1'b0 || y1 !== 1'b1 || y_valid1 !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_rst: y8=%h v8=%b y1=%b v1=%b want ff/0/1/0",
                     y8, y_valid8, y1, y_valid1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (y8 !== 8'h00 || y_valid8 !== 1'b1 || y1 !== 1'b0 || y_valid1 !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_cap: y8=%h v8=%b y1=%b v1=%b want 00/1/0/1",
                     y8, y_valid8, y1, y_valid1);
        end
    endtask

    task automatic test_hold();
        logic [7:0] cap;
        logic [7:0] ra, rb, rc, rd;
        @(posedge clk); #1;
        a = 8'h3C; b = 8'h5A; c = 8'h0F; d = 8'hF3; mode = 2'd0; in_valid = 1'b1;
        cap = ref_f(8'h3C, 8'h5A, 8'h0F, 8'hF3, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom); rd = 8'($urandom);
            a = ra; b = rb; c = rc; d = rd; in_valid = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (y8 !== cap || y_valid8 !== (i == 0) || y1 !== cap[0] || y_valid1 !== (i == 0)) begin
                n_bad++;
                $display("FAIL hold idle %0d: y8=%h v8=%b y1=%b v1=%b want y=%h valid=%b",
                         i, y8, y_valid8, y1, y_valid1, cap, (i == 0));
            end
            n_cmp++;
            if (y_comb8 !== ref_f(ra, rb, rc, rd, 0)) begin
                n_bad++;
                $display("FAIL hold_comb %0d: y_comb=%h want %h", i, y_comb8, ref_f(ra, rb, rc, rd, 0));
            end
        end
    endtask

    task automatic test_lanes();
        @(posedge clk); #1;
        a = 8'hF0; b = 8'hFF; c = 8'h0F; d = 8'h03; mode = 2'd0; in_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (y_comb8 !== 8'h0C || y_comb1 !== 1'b0) begin
            n_bad++;
            $display("FAIL lanes: y_comb8=%h y_comb1=%b want 0c/0", y_comb8, y_comb1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (y8 !== 8'h0C || y_valid8 !== 1'b1) begin
            n_bad++;
            $display("FAIL lanes_reg: y=%h v=%b want 0c/1", y8, y_valid8);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_y = 8'hFF;
        logic       exp_v = 1'b0;
        logic [7:0] ra, rb, rc, rd, rf;
        int         rm;
        logic       rv, rr;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom); rd = 8'($urandom);
            rm = int'($urandom_range(0, 3));
            rv = ($urandom_range(0, 3) != 0);
            rr = (i == 0) || ($urandom_range(0, 15) == 0);
            a = ra; b = rb; c = rc; d = rd; mode = 2'(rm); in_valid = rv; rst = rr;
            rf = ref_f(ra, rb, rc, rd, rm);
            @(negedge clk);
            n_cmp++;
            if (y_comb8 !== rf || y_comb1 !== rf[0]) begin
                n_bad++;
                $display("FAIL rand_comb %0d mode=%0d: y_comb8=%h y_comb1=%b want %h",
                         i, rm, y_comb8, y_comb1, rf);
            end
            if (i > 0) begin
                n_cmp++;
                if (y8 !== exp_y || y_valid8 !== exp_v || y1 !== exp_y[0] || y_valid1 !== exp_v) begin
                    n_bad++;
                    $display("FAIL rand_reg %0d: y8=%h v8=%b y1=%b v1=%b want y=%h valid=%b",
                             i, y8, y_valid8, y1, y_valid1, exp_y, exp_v);
                end
            end
            if (rr) begin
                exp_y = 8'hFF;
                exp_v = 1'b0;
            end else if (rv) begin
                exp_y = rf;
                exp_v = 1'b1;
            end else begin
                exp_v = 1'b0;
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        a = 8'h00; b = 8'h00; c = 8'h00; d = 8'h00; mode = 2'd0;
        test_reset();
        test_sweep_aoi22();
        test_modes();
        test_reset_midstream();
        test_hold();
        test_lanes();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_aoi
